// File: rtl/equation_scheduler_pkg.sv
// Shared definitions for the equation scheduler: state encoding, sizes and
// small helpers used by the scheduler and its interface.
package equation_scheduler_pkg;

  localparam int NUM_EQ             = 3;
  localparam int IDX_W              = 2;
  localparam int TIME_LIMIT_DEFAULT = 20;
  localparam int CLK_HZ_DEFAULT     = 50_000_000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_SEQ  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [NUM_EQ-1:0] eq_onehot(input logic [IDX_W-1:0] idx);
    return NUM_EQ'(1) << idx;
  endfunction

  // Wrong-answer counter stops at its maximum instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/equation_scheduler_if.sv
// Signals between the scheduler and the equation datapaths / penalty sequencer.
// eq_done is a one-cycle pulse and eq_correct is only meaningful with it;
// sequencer_req stays high until seq_ack is sampled high, then drops.
interface equation_scheduler_if;
  import equation_scheduler_pkg::*;

  logic [NUM_EQ-1:0] eq_start;
  logic              eq_clear;
  logic              eq_done;
  logic              eq_correct;
  logic              sequencer_req;
  logic              seq_ack;

  modport master (
    output eq_start, eq_clear, sequencer_req,
    input  eq_done, eq_correct, seq_ack
  );

  modport slave (
    input  eq_start, eq_clear, sequencer_req,
    output eq_done, eq_correct, seq_ack
  );

endinterface

// File: rtl/equation_scheduler_tick_prescaler.sv
// One-second strobe: counts 0..CLK_HZ-1 while enabled and pulses tick on the
// terminal count, then wraps.
module tick_prescaler
  import equation_scheduler_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLK_HZ - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == TERMINAL) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && (count == TERMINAL);

endmodule

// File: rtl/equation_scheduler.sv
// Round scheduler: walks three equations in order, times each attempt,
// counts wrong answers/timeouts and requests a penalty sequence if needed.
module equation_scheduler
  import equation_scheduler_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int TIME_LIMIT = TIME_LIMIT_DEFAULT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  equation_scheduler_if.master bus,
  output logic [4:0]           seconds_left,
  output logic [NUM_EQ-1:0]    correct_mask,
  output logic [3:0]           wrong_count,
  output logic                 done,
  output state_t               state_dbg
);

  localparam logic [4:0]       TL       = 5'(TIME_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EQ - 1);

  state_t            state;
  logic [IDX_W-1:0]  index;
  logic [NUM_EQ-1:0] eq_start_r;
  logic              eq_clear_r;
  logic              seq_req_r;
  logic              done_r;
  logic              tick;

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (state == S_RUN),
    .clear  (state == S_ARM),
    .tick   (tick)
  );

  // Control outputs are registered alongside the state they belong to.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      index        <= '0;
      seconds_left <= TL;
      correct_mask <= '0;
      wrong_count  <= '0;
      eq_start_r   <= '0;
      eq_clear_r   <= 1'b0;
      seq_req_r    <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state        <= S_ARM;
            index        <= '0;
            correct_mask <= '0;
            wrong_count  <= '0;
            eq_clear_r   <= 1'b1;
          end
        end
        S_ARM: begin
          state        <= S_RUN;
          eq_clear_r   <= 1'b0;
          eq_start_r   <= eq_onehot(index);
          seconds_left <= TL;
        end
        S_RUN: begin
          // A completed comparison wins over a coincident timeout tick.
          if (bus.eq_done) begin
            eq_start_r <= '0;
            if (bus.eq_correct) begin
              correct_mask[index] <= 1'b1;
              if (index != LAST_IDX) begin
                index      <= index + IDX_W'(1);
                state      <= S_ARM;
                eq_clear_r <= 1'b1;
              end else if (wrong_count != 4'd0) begin
                state     <= S_SEQ;
                seq_req_r <= 1'b1;
              end else begin
                state  <= S_DONE;
                done_r <= 1'b1;
              end
            end else begin
              wrong_count <= sat_inc(wrong_count);
              state       <= S_ARM;
              eq_clear_r  <= 1'b1;
            end
          end else if (tick) begin
            if (seconds_left == 5'd0) begin
              wrong_count <= sat_inc(wrong_count);
              state       <= S_ARM;
              eq_clear_r  <= 1'b1;
              eq_start_r  <= '0;
            end else begin
              seconds_left <= seconds_left - 5'd1;
            end
          end
        end
        S_SEQ: begin
          if (bus.seq_ack) begin
            state     <= S_DONE;
            seq_req_r <= 1'b0;
            done_r    <= 1'b1;
          end
        end
        S_DONE: begin
          if (!Start) begin
            state  <= S_IDLE;
            done_r <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset silences the control outputs in the very cycle it is asserted.
  assign bus.eq_start      = Reset ? '0 : eq_start_r;
  assign bus.eq_clear      = eq_clear_r & ~Reset;
  assign bus.sequencer_req = seq_req_r & ~Reset;
  assign done              = done_r & ~Reset;
  assign state_dbg         = state;

endmodule

// File: tb/tb_equation_scheduler.sv
// Randomized bench for equation_scheduler with a round-level reference model
// (attempt outcomes -> expected index, mask, wrong count and round ending).
module tb_equation_scheduler;
  import equation_scheduler_pkg::*;

  localparam int CLK_HZ_TB = 4;
  localparam int TL_TB     = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] seconds_left;
  logic [2:0] correct_mask;
  logic [3:0] wrong_count;
  logic       done;
  state_t     state_dbg;

  equation_scheduler_if bus();

  equation_scheduler #(.CLK_HZ(CLK_HZ_TB), .TIME_LIMIT(TL_TB)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .Start        (start),
    .bus          (bus),
    .seconds_left (seconds_left),
    .correct_mask (correct_mask),
    .wrong_count  (wrong_count),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model of round progress.
  int m_index;
  int m_mask;
  int m_wrong;
  logic [2:0] exp_q[$];
  bit seq_seen;

  always @(negedge clk) if (bus.sequencer_req === 1'b1) seq_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_new_round();
    m_index = 0; m_mask = 0; m_wrong = 0; seq_seen = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.eq_start !== 3'b000) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_run: eq_start stayed %b, required nonzero", bus.eq_start); end
  endtask

  // kind: 0 correct answer, 1 wrong answer, 2 let the attempt time out.
  task automatic do_attempt(input int kind, input int delay);
    bit ok;
    bit last;
    logic [2:0] exp_start;
    int cycles;
    wait_run(ok);
    if (!ok) return;
    exp_q.push_back(3'(1 << m_index));
    exp_start = exp_q.pop_front();
    total++;
    if (bus.eq_start !== exp_start) begin bad++; $display("FAIL eq_start: got %b expected %b", bus.eq_start, exp_start); end
    total++;
    if (seconds_left !== 5'(TL_TB)) begin bad++; $display("FAIL reload: got %0d expected %0d", seconds_left, TL_TB); end
    last = (kind == 0) && (m_index == 2);
    if (kind == 2) begin
      cycles = 0;
      while (bus.eq_clear !== 1'b1 && cycles < 40) begin @(negedge clk); cycles++; end
      total++;
      if (cycles != 4 * (TL_TB + 1)) begin bad++; $display("FAIL timeout_cycles: got %0d expected %0d", cycles, 4 * (TL_TB + 1)); end
    end else begin
      for (int i = 0; i < delay; i++) begin
        bus.seq_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.seq_ack = 1'b0;
      bus.eq_done = 1'b1; bus.eq_correct = (kind == 0);
      @(negedge clk);
      bus.eq_done = 1'b0; bus.eq_correct = 1'b0;
      if (!last) begin
        total++;
        if (bus.eq_clear !== 1'b1) begin bad++; $display("FAIL eq_clear_pulse: got %b expected 1", bus.eq_clear); end
      end
    end
    if (kind == 0) begin
      m_mask = m_mask | (1 << m_index);
      if (m_index < 2) m_index++;
    end else begin
      m_wrong = (m_wrong < 15) ? m_wrong + 1 : 15;
    end
    total++;
    if (correct_mask !== 3'(m_mask)) begin bad++; $display("FAIL correct_mask: got %b expected %b", correct_mask, 3'(m_mask)); end
    total++;
    if (wrong_count !== 4'(m_wrong)) begin bad++; $display("FAIL wrong_count: got %0d expected %0d", wrong_count, m_wrong); end
  endtask

  task automatic finish_round();
    int hold;
    if (m_wrong > 0) begin
      total++;
      if (bus.sequencer_req !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL seq_enter: req=%b done=%b expected req=1 done=0", bus.sequencer_req, done); end
      hold = $urandom_range(1, 4);
      cyc(hold);
      total++;
      if (bus.sequencer_req !== 1'b1) begin bad++; $display("FAIL seq_hold: got %b expected 1", bus.sequencer_req); end
      bus.seq_ack = 1'b1;
      @(negedge clk);
      bus.seq_ack = 1'b0;
    end
    total++;
    if (done !== 1'b1 || bus.sequencer_req !== 1'b0) begin bad++; $display("FAIL round_done: done=%b req=%b expected done=1 req=0", done, bus.sequencer_req); end
    total++;
    if (correct_mask !== 3'b111) begin bad++; $display("FAIL final_mask: got %b expected 111", correct_mask); end
    bus.eq_done = 1'b1; bus.eq_correct = 1'b0;
    @(negedge clk);
    bus.eq_done = 1'b0;
    total++;
    if (wrong_count !== 4'(m_wrong) || done !== 1'b1) begin bad++; $display("FAIL done_ignores_eq_done: wc=%0d done=%b expected wc=%0d done=1", wrong_count, done, m_wrong); end
    start = 1'b0;
    @(negedge clk);
    total++;
    if (state_dbg !== S_IDLE || done !== 1'b0) begin bad++; $display("FAIL release: state=%0d done=%b expected IDLE done=0", state_dbg, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    total++;
    if (state_dbg !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
    total++;
    if (bus.eq_start !== 3'b000 || bus.eq_clear !== 1'b0 || bus.sequencer_req !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: start=%b clr=%b req=%b done=%b expected all 0", bus.eq_start, bus.eq_clear, bus.sequencer_req, done);
    end
    total++;
    if (seconds_left !== 5'(TL_TB) || correct_mask !== 3'b000 || wrong_count !== 4'd0) begin
      bad++; $display("FAIL reset_regs: secs=%0d mask=%b wc=%0d expected %0d 000 0", seconds_left, correct_mask, wrong_count, TL_TB);
    end
    rst = 1'b0;
    cyc(1);
    total++;
    if (state_dbg !== S_IDLE) begin bad++; $display("FAIL idle_hold: got %0d expected %0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_clean_round();
    model_new_round();
    start = 1'b1;
    cyc(1);
    total++;
    if (state_dbg !== S_ARM || bus.eq_clear !== 1'b1) begin bad++; $display("FAIL arm_entry: state=%0d clr=%b expected ARM clr=1", state_dbg, bus.eq_clear); end
    for (int i = 0; i < 3; i++) do_attempt(0, $urandom_range(0, 8));
    total++;
    if (seq_seen !== 1'b0) begin bad++; $display("FAIL clean_no_seq: got %b expected 0", seq_seen); end
    finish_round();
  endtask

  task automatic test_wrong_then_penalty();
    model_new_round();
    start = 1'b1;
    do_attempt(1, $urandom_range(0, 5));
    for (int i = 0; i < 3; i++) do_attempt(0, $urandom_range(0, 5));
    finish_round();
  endtask

  task automatic test_timeout();
    bit ok;
    model_new_round();
    start = 1'b1;
    wait_run(ok);
    for (int k = 0; k < 4 * (TL_TB + 1); k++) begin
      total++;
      if (seconds_left !== 5'(TL_TB - k / 4)) begin bad++; $display("FAIL countdown[%0d]: got %0d expected %0d", k, seconds_left, TL_TB - k / 4); end
      @(negedge clk);
    end
    m_wrong = 1;
    total++;
    if (state_dbg !== S_ARM || bus.eq_clear !== 1'b1 || wrong_count !== 4'd1) begin
      bad++; $display("FAIL timeout_arm: state=%0d clr=%b wc=%0d expected ARM 1 1", state_dbg, bus.eq_clear, wrong_count);
    end
    for (int i = 0; i < 3; i++) do_attempt(0, $urandom_range(0, 5));
    finish_round();
  endtask

  task automatic test_priority();
    bit ok;
    model_new_round();
    start = 1'b1;
    wait_run(ok);
    cyc(4 * (TL_TB + 1) - 1);
    bus.eq_done = 1'b1; bus.eq_correct = 1'b1;
    @(negedge clk);
    bus.eq_done = 1'b0; bus.eq_correct = 1'b0;
    m_mask = 1; m_index = 1;
    total++;
    if (bus.eq_clear !== 1'b1 || wrong_count !== 4'd0 || correct_mask !== 3'b001) begin
      bad++; $display("FAIL priority: clr=%b wc=%0d mask=%b expected 1 0 001", bus.eq_clear, wrong_count, correct_mask);
    end
    for (int i = 0; i < 2; i++) do_attempt(0, $urandom_range(0, 5));
    finish_round();
  endtask

  task automatic test_saturation();
    model_new_round();
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_attempt(1, $urandom_range(0, 3));
      if (i == 0) start = 1'b0;
    end
    total++;
    if (wrong_count !== 4'd15) begin bad++; $display("FAIL saturate: got %0d expected 15", wrong_count); end
    start = 1'b1;
    for (int i = 0; i < 3; i++) do_attempt(0, $urandom_range(0, 3));
    finish_round();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    model_new_round();
    start = 1'b1;
    do_attempt(0, 1);
    wait_run(ok);
    rst = 1'b1;
    #1;
    total++;
    if (bus.eq_start !== 3'b000 || done !== 1'b0) begin bad++; $display("FAIL reset_same_cycle: start=%b done=%b expected 000 0", bus.eq_start, done); end
    @(negedge clk);
    total++;
    if (state_dbg !== S_IDLE || bus.eq_start !== 3'b000 || bus.eq_clear !== 1'b0 || bus.sequencer_req !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outputs: state=%0d start=%b clr=%b req=%b expected IDLE 000 0 0", state_dbg, bus.eq_start, bus.eq_clear, bus.sequencer_req);
    end
    total++;
    if (correct_mask !== 3'b000 || wrong_count !== 4'd0 || seconds_left !== 5'(TL_TB)) begin
      bad++; $display("FAIL mid_reset_regs: mask=%b wc=%0d secs=%0d expected 000 0 %0d", correct_mask, wrong_count, seconds_left, TL_TB);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (state_dbg !== S_ARM) begin bad++; $display("FAIL rearm: got %0d expected %0d", state_dbg, S_ARM); end
    @(negedge clk);
    total++;
    if (bus.eq_start !== 3'b001) begin bad++; $display("FAIL restart_index: got %b expected 001", bus.eq_start); end
    rst = 1'b1; start = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_random_rounds();
    int kind;
    int r;
    int attempts;
    for (int round = 0; round < 3; round++) begin
      model_new_round();
      start = 1'b1;
      attempts = 0;
      while (m_mask != 7) begin
        r = $urandom_range(0, 99);
        kind = (attempts > 12 || r < 50) ? 0 : (r < 85) ? 1 : 2;
        start = 1'($urandom_range(0, 1));
        if (kind == 0 && m_index == 2) start = 1'b1;
        do_attempt(kind, $urandom_range(0, 10));
        attempts++;
      end
      finish_round();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    bus.eq_done = 1'b0; bus.eq_correct = 1'b0; bus.seq_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_round();
    test_wrong_then_penalty();
    test_timeout();
    test_priority();
    test_saturation();
    test_reset_mid_run();
    test_random_rounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
